// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID/EX pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN       = 2'd0,
    CTRL_LOAD_WAIT = 2'd1,
    CTRL_HALT      = 2'd2,
    CTRL_ERROR     = 2'd3
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// 8-bit load-wait counter; expire flags the last cycle before the timeout trap.
module wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) cnt <= '0;
    else if (inc)    cnt <= cnt + 8'd1;
  end

  assign expire = (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: jump redirect, load stall, debug halt, load-timeout trap.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_wen,
  input  logic        ex_mem_req,
  input  logic        mem_rdy,
  input  logic        ex_jump_en,
  input  logic [31:0] ex_jump_addr,
  input  logic        halt_req,
  output logic        pc_hold,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_flush,
  output logic        rs1_fwd,
  output logic        rs2_fwd,
  output logic        halt_ack,
  output logic        bus_err
);

  ctrl_state_t state, state_nxt;
  logic        load_stall, expire;

  assign load_stall = ex_mem_req & ~mem_rdy;

  wait_timer #(.LIMIT(LOAD_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == CTRL_RUN),
    .inc    ((state == CTRL_LOAD_WAIT) & ~mem_rdy),
    .expire (expire)
  );

  always_comb begin
    pc_hold     = 1'b0;
    pc_load     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_hold  = 1'b0;
    id_ex_flush = 1'b0;
    state_nxt   = state;
    case (state)
      CTRL_RUN: begin
        if (ex_jump_en) begin
          pc_load     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_stall) begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
          state_nxt  = CTRL_LOAD_WAIT;
        end else if (halt_req) begin
          state_nxt = CTRL_HALT;
        end
      end
      CTRL_LOAD_WAIT: begin
        pc_hold    = ~mem_rdy;
        if_id_hold = ~mem_rdy;
        id_ex_hold = ~mem_rdy;
        if (mem_rdy)     state_nxt = CTRL_RUN;
        else if (expire) state_nxt = CTRL_ERROR;
      end
      CTRL_HALT: begin
        // EX gets a bubble so the held ID instruction is not executed twice
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
        if (!halt_req) state_nxt = CTRL_RUN;
      end
      default: begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end
    endcase
  end

  assign pc_load_addr = pc_load ? ex_jump_addr : 32'h0;

  // A load still waiting for data has no result to forward; x0 is never forwarded
  assign rs1_fwd = ex_rd_wen & (ex_rd_addr == id_rs1_addr) & (|id_rs1_addr) & ~load_stall;
  assign rs2_fwd = ex_rd_wen & (ex_rd_addr == id_rs2_addr) & (|id_rs2_addr) & ~load_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CTRL_RUN;
      halt_ack <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      halt_ack <= (state_nxt == CTRL_HALT);
      bus_err  <= (state_nxt == CTRL_ERROR);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed check of pipe_ctrl against a flag-based behavioural model.
module tb_pipe_ctrl;
  localparam int LT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        ex_rd_wen, ex_mem_req, mem_rdy, ex_jump_en, halt_req;
  logic [31:0] ex_jump_addr;
  logic        pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic        rs1_fwd, rs2_fwd, halt_ack, bus_err;
  logic [31:0] pc_load_addr;

  int n_chk = 0;
  int n_err = 0;

  // model: which situation the controller is in, and how long a load has waited
  bit m_err, m_halt, m_wait;
  int wait_age;

  always #5 clk = ~clk;

  pipe_ctrl #(.LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
    .ex_mem_req(ex_mem_req), .mem_rdy(mem_rdy),
    .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
    .halt_req(halt_req),
    .pc_hold(pc_hold), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .halt_ack(halt_ack), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_ctl();
    return {pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold,
            id_ex_flush, rs1_fwd, rs2_fwd, halt_ack, bus_err};
  endfunction

  function automatic bit fwd(input logic [4:0] rs);
    return ex_rd_wen && rs != 0 && rs == ex_rd_addr && !(ex_mem_req && !mem_rdy);
  endfunction

  function automatic logic [9:0] model_ctl();
    bit run, stall, hold_all;
    run      = !m_err && !m_halt && !m_wait;
    stall    = (run && !ex_jump_en && ex_mem_req && !mem_rdy) || (m_wait && !mem_rdy);
    hold_all = stall || m_halt || m_err;
    return {hold_all, run && ex_jump_en, hold_all, run && ex_jump_en, stall,
            (run && ex_jump_en) || m_halt || m_err,
            fwd(id_rs1_addr), fwd(id_rs2_addr), m_halt, m_err};
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_err = 0; m_halt = 0; m_wait = 0; wait_age = 0;
    end else if (m_err) begin
    end else if (m_wait) begin
      if (mem_rdy) m_wait = 0;
      else begin
        wait_age++;
        if (wait_age == LT) begin m_wait = 0; m_err = 1; end
      end
    end else if (m_halt) begin
      if (!halt_req) m_halt = 0;
    end else if (!ex_jump_en) begin
      if (ex_mem_req && !mem_rdy) begin m_wait = 1; wait_age = 0; end
      else if (halt_req) m_halt = 1;
    end
  endtask

  // compare mid-cycle, clock it, update model, come back at the falling edge
  task automatic cycle();
    logic [9:0]  ec;
    logic [31:0] ea;
    #1;
    ec = model_ctl();
    ea = ec[8] ? ex_jump_addr : 32'h0;
    chk("ctl", {22'h0, dut_ctl()}, {22'h0, ec});
    chk("pc_addr", pc_load_addr, ea);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1; id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0; ex_rd_wen = 0;
    ex_mem_req = 0; mem_rdy = 0; ex_jump_en = 0; ex_jump_addr = 0; halt_req = 0;
  endtask

  initial begin
    idle();
    rst = 0;
    @(negedge clk);
    cycle(); cycle();
    idle();
    #1;
    chk("rst_idle", {22'h0, dut_ctl()}, 32'h0);
    chk("rst_addr", pc_load_addr, 32'h0);
    cycle();

    // jump
    ex_jump_en = 1; ex_jump_addr = 32'h0000_0040;
    #1;
    chk("jmp_ctl", {pc_load, if_id_flush, id_ex_flush}, 32'h7);
    chk("jmp_addr", pc_load_addr, 32'h40);
    cycle();
    idle();
    #1;
    chk("jmp_after", {pc_hold, if_id_hold, id_ex_hold}, 32'h0);
    cycle();

    // load stall released in the mem_rdy cycle
    ex_mem_req = 1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("ld_hold", {pc_hold, if_id_hold, id_ex_hold}, 32'h7);
      cycle();
    end
    mem_rdy = 1;
    #1; chk("ld_rel", {pc_hold, if_id_hold, id_ex_hold}, 32'h0);
    cycle();
    idle(); cycle();

    // forwarding
    ex_rd_wen = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_rs2_addr = 0;
    #1; chk("fwd_5", {rs1_fwd, rs2_fwd}, 32'h2);
    cycle();
    ex_rd_addr = 0; id_rs1_addr = 0;
    #1; chk("fwd_x0", {rs1_fwd, rs2_fwd}, 32'h0);
    cycle();
    idle();

    // halt, with a jump taken first
    halt_req = 1; ex_jump_en = 1; ex_jump_addr = 32'h100;
    cycle();
    ex_jump_en = 0;
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1; chk("halt_ack", {halt_ack, id_ex_flush}, 32'h3);
      cycle();
    end
    halt_req = 0;
    cycle();
    #1; chk("halt_rel", halt_ack, 32'h0);
    cycle();

    // load timeout
    ex_mem_req = 1;
    for (int k = 0; k < 20; k++) begin
      if (k == 16) begin #1; chk("to_t16", bus_err, 32'h0); end
      if (k == 17) begin #1; chk("to_t17", bus_err, 32'h1); end
      cycle();
    end
    idle(); cycle();
    #1; chk("err_sticky", bus_err, 32'h1);
    rst = 0; cycle(); rst = 1;
    #1; chk("err_clr", {22'h0, dut_ctl()}, 32'h0);
    cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(63) != 0);
      id_rs1_addr  = 5'($urandom_range(3));
      id_rs2_addr  = 5'($urandom_range(3));
      ex_rd_addr   = 5'($urandom_range(3));
      ex_rd_wen    = $urandom_range(1);
      ex_jump_en   = ($urandom_range(5) == 0);
      ex_jump_addr = $urandom;
      ex_mem_req   = ($urandom_range(3) == 0);
      mem_rdy      = ($urandom_range(2) == 0);
      halt_req     = ($urandom_range(7) == 0) || (m_halt && $urandom_range(1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
